// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 round-constant sequencer: FSM states,
// round counts and mode encodings.
package sha2_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  localparam logic MODE_256 = 1'b0;
  localparam logic MODE_512 = 1'b1;

  function automatic logic [6:0] last_round(input logic mode);
    return (mode == MODE_512) ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);
  endfunction

endpackage

// File: rtl/sha2_k_rom.sv
// Combinational 80x64 SHA-512 round-constant table; the SHA-256 constants
// are the upper halves of the first 64 entries.
module sha2_k_rom (
  input  logic [6:0]  idx_i,
  output logic [63:0] k_o
);

  always_comb begin
    k_o = 64'h0;
    case (idx_i)
      7'd0:  k_o = 64'h428a2f98d728ae22;
      7'd1:  k_o = 64'h7137449123ef65cd;
      7'd2:  k_o = 64'hb5c0fbcfec4d3b2f;
      7'd3:  k_o = 64'he9b5dba58189dbbc;
      7'd4:  k_o = 64'h3956c25bf348b538;
      7'd5:  k_o = 64'h59f111f1b605d019;
      7'd6:  k_o = 64'h923f82a4af194f9b;
      7'd7:  k_o = 64'hab1c5ed5da6d8118;
      7'd8:  k_o = 64'hd807aa98a3030242;
      7'd9:  k_o = 64'h12835b0145706fbe;
      7'd10: k_o = 64'h243185be4ee4b28c;
      7'd11: k_o = 64'h550c7dc3d5ffb4e2;
      7'd12: k_o = 64'h72be5d74f27b896f;
      7'd13: k_o = 64'h80deb1fe3b1696b1;
      7'd14: k_o = 64'h9bdc06a725c71235;
      7'd15: k_o = 64'hc19bf174cf692694;
      7'd16: k_o = 64'he49b69c19ef14ad2;
      7'd17: k_o = 64'hefbe4786384f25e3;
      7'd18: k_o = 64'h0fc19dc68b8cd5b5;
      7'd19: k_o = 64'h240ca1cc77ac9c65;
      7'd20: k_o = 64'h2de92c6f592b0275;
      7'd21: k_o = 64'h4a7484aa6ea6e483;
      7'd22: k_o = 64'h5cb0a9dcbd41fbd4;
      7'd23: k_o = 64'h76f988da831153b5;
      7'd24: k_o = 64'h983e5152ee66dfab;
      7'd25: k_o = 64'ha831c66d2db43210;
      7'd26: k_o = 64'hb00327c898fb213f;
      7'd27: k_o = 64'hbf597fc7beef0ee4;
      7'd28: k_o = 64'hc6e00bf33da88fc2;
      7'd29: k_o = 64'hd5a79147930aa725;
      7'd30: k_o = 64'h06ca6351e003826f;
      7'd31: k_o = 64'h142929670a0e6e70;
      7'd32: k_o = 64'h27b70a8546d22ffc;
      7'd33: k_o = 64'h2e1b21385c26c926;
      7'd34: k_o = 64'h4d2c6dfc5ac42aed;
      7'd35: k_o = 64'h53380d139d95b3df;
      7'd36: k_o = 64'h650a73548baf63de;
      7'd37: k_o = 64'h766a0abb3c77b2a8;
      7'd38: k_o = 64'h81c2c92e47edaee6;
      7'd39: k_o = 64'h92722c851482353b;
      7'd40: k_o = 64'ha2bfe8a14cf10364;
      7'd41: k_o = 64'ha81a664bbc423001;
      7'd42: k_o = 64'hc24b8b70d0f89791;
      7'd43: k_o = 64'hc76c51a30654be30;
      7'd44: k_o = 64'hd192e819d6ef5218;
      7'd45: k_o = 64'hd69906245565a910;
      7'd46: k_o = 64'hf40e35855771202a;
      7'd47: k_o = 64'h106aa07032bbd1b8;
      7'd48: k_o = 64'h19a4c116b8d2d0c8;
      7'd49: k_o = 64'h1e376c085141ab53;
      7'd50: k_o = 64'h2748774cdf8eeb99;
      7'd51: k_o = 64'h34b0bcb5e19b48a8;
      7'd52: k_o = 64'h391c0cb3c5c95a63;
      7'd53: k_o = 64'h4ed8aa4ae3418acb;
      7'd54: k_o = 64'h5b9cca4f7763e373;
      7'd55: k_o = 64'h682e6ff3d6b2b8a3;
      7'd56: k_o = 64'h748f82ee5defb2fc;
      7'd57: k_o = 64'h78a5636f43172f60;
      7'd58: k_o = 64'h84c87814a1f0ab72;
      7'd59: k_o = 64'h8cc702081a6439ec;
      7'd60: k_o = 64'h90befffa23631e28;
      7'd61: k_o = 64'ha4506cebde82bde9;
      7'd62: k_o = 64'hbef9a3f7b2c67915;
      7'd63: k_o = 64'hc67178f2e372532b;
      7'd64: k_o = 64'hca273eceea26619c;
      7'd65: k_o = 64'hd186b8c721c0c207;
      7'd66: k_o = 64'heada7dd6cde0eb1e;
      7'd67: k_o = 64'hf57d4f7fee6ed178;
      7'd68: k_o = 64'h06f067aa72176fba;
      7'd69: k_o = 64'h0a637dc5a2c898a6;
      7'd70: k_o = 64'h113f9804bef90dae;
      7'd71: k_o = 64'h1b710b35131c471b;
      7'd72: k_o = 64'h28db77f523047d84;
      7'd73: k_o = 64'h32caab7b40c72493;
      7'd74: k_o = 64'h3c9ebe0a15c9bebc;
      7'd75: k_o = 64'h431d67c49c100d4c;
      7'd76: k_o = 64'h4cc5d4becb3e42b6;
      7'd77: k_o = 64'h597f299cfc657e2a;
      7'd78: k_o = 64'h5fcb6fab3ad6faec;
      7'd79: k_o = 64'h6c44198c4a475817;
      default: k_o = 64'h0;
    endcase
  end

endmodule

// File: rtl/sha2_k_sequencer.sv
// Streams SHA-224/256 or SHA-384/512 round constants K[t] over a
// valid/ready handshake, one per cycle, with all outputs registered.
module sha2_k_sequencer #(
  parameter int SUPPORT_512 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  input  logic        k_ready,
  output logic        k_valid,
  output logic [63:0] k_word,
  output logic [6:0]  k_round,
  output logic        k_last,
  output logic        busy
);
  import sha2_pkg::*;

  state_e      state_q;
  logic        mode_q;
  logic [6:0]  round_q;
  logic        k_valid_q;
  logic [63:0] k_word_q;
  logic        k_last_q;

  logic        start_mode;
  logic        word_mode;
  logic [6:0]  round_d;
  logic [63:0] rom_k;
  logic [63:0] k_word_d;

  assign start_mode = (SUPPORT_512 != 0) ? mode : MODE_256;

  // The ROM is addressed with the round about to be registered, so the word
  // and its index land in their output flops on the same edge.
  always_comb begin
    round_d   = 7'd0;
    word_mode = start_mode;
    if (state_q == ST_RUN) begin
      round_d   = round_q + 7'd1;
      word_mode = mode_q;
    end
    k_word_d = (word_mode == MODE_512) ? rom_k : {32'h0, rom_k[63:32]};
  end

  sha2_k_rom u_rom (
    .idx_i (round_d),
    .k_o   (rom_k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_256;
      round_q   <= 7'd0;
      k_valid_q <= 1'b0;
      k_word_q  <= 64'h0;
      k_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q   <= ST_RUN;
            mode_q    <= start_mode;
            round_q   <= round_d;
            k_word_q  <= k_word_d;
            k_valid_q <= 1'b1;
            k_last_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Abort wins over a handshake; both paths leave clean zeroed outputs.
          if (abort || (k_ready && k_last_q)) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_256;
            round_q   <= 7'd0;
            k_valid_q <= 1'b0;
            k_word_q  <= 64'h0;
            k_last_q  <= 1'b0;
          end else if (k_ready) begin
            round_q  <= round_d;
            k_word_q <= k_word_d;
            k_last_q <= (round_d == last_round(mode_q));
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign k_valid = k_valid_q;
  assign k_word  = k_word_q;
  assign k_round = round_q;
  assign k_last  = k_last_q;
  assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// Directed bench for sha2_k_sequencer: full SHA-256/512 sequences,
// backpressure, abort, asynchronous reset and the SHA-256-only build.
module tb_sha2_k_sequencer;

  logic        clk;
  logic        rst;
  logic        start, mode, abort, kReady;
  logic        kValid, kLast, busy;
  logic [63:0] kWord;
  logic [6:0]  kRound;

  logic        start2, mode2, abort2, kReady2;
  logic        kValid2, kLast2, busy2;
  logic [63:0] kWord2;
  logic [6:0]  kRound2;

  int checks = 0;
  int passes = 0;

  sha2_k_sequencer #(.SUPPORT_512(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .k_ready(kReady), .k_valid(kValid), .k_word(kWord), .k_round(kRound),
    .k_last(kLast), .busy(busy)
  );

  sha2_k_sequencer #(.SUPPORT_512(0)) dut256 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .abort(abort2),
    .k_ready(kReady2), .k_valid(kValid2), .k_word(kWord2), .k_round(kRound2),
    .k_last(kLast2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startSeq(input logic m);
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic advanceTo(input int target, output bit reached);
    for (int i = 0; i < 200 && !(kValid && kRound == 7'(target)); i++) step();
    reached = kValid && (kRound == 7'(target));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; mode = 0; abort = 0; kReady = 0;
    start2 = 0; mode2 = 0; abort2 = 0; kReady2 = 0;
    step(); step();
    checks++; if (kValid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", kValid); else passes++;
    checks++; if (kWord !== 64'h0) $display("[TB] FAIL rst_word: got %h want 0", kWord); else passes++;
    checks++; if (kRound !== 7'd0) $display("[TB] FAIL rst_round: got %0d want 0", kRound); else passes++;
    checks++; if (kLast !== 1'b0) $display("[TB] FAIL rst_last: got %b want 0", kLast); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else passes++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_mode0();
    int hs = 0; int seqErr = 0; int lastErr = 0;
    kReady = 1'b1;
    startSeq(1'b0);
    checks++; if (kValid !== 1'b1) $display("[TB] FAIL m0_valid0: got %b want 1", kValid); else passes++;
    checks++; if (kWord !== 64'h00000000428a2f98) $display("[TB] FAIL m0_word0: got %h want 00000000428a2f98", kWord); else passes++;
    for (int i = 0; i < 100 && kValid; i++) begin
      if (kRound !== 7'(i)) seqErr++;
      if (kLast !== (i == 63)) lastErr++;
      if (i == 63) begin
        checks++; if (kWord !== 64'h00000000c67178f2) $display("[TB] FAIL m0_word63: got %h want 00000000c67178f2", kWord); else passes++;
        checks++; if (kLast !== 1'b1) $display("[TB] FAIL m0_last63: got %b want 1", kLast); else passes++;
      end
      hs++;
      step();
    end
    checks++; if (hs != 64) $display("[TB] FAIL m0_count: got %0d want 64", hs); else passes++;
    checks++; if (seqErr != 0) $display("[TB] FAIL m0_order: got %0d bad rounds want 0", seqErr); else passes++;
    checks++; if (lastErr != 0) $display("[TB] FAIL m0_lastflag: got %0d bad flags want 0", lastErr); else passes++;
    checks++; if (kValid !== 1'b0) $display("[TB] FAIL m0_end_valid: got %b want 0", kValid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL m0_end_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_mode1();
    int hs = 0; int seqErr = 0;
    kReady = 1'b1;
    startSeq(1'b1);
    checks++; if (kWord !== 64'h428a2f98d728ae22) $display("[TB] FAIL m1_word0: got %h want 428a2f98d728ae22", kWord); else passes++;
    for (int i = 0; i < 120 && kValid; i++) begin
      if (kRound !== 7'(i)) seqErr++;
      if (i == 63) begin
        checks++; if (kWord !== 64'hc67178f2e372532b) $display("[TB] FAIL m1_word63: got %h want c67178f2e372532b", kWord); else passes++;
        checks++; if (kLast !== 1'b0) $display("[TB] FAIL m1_last63: got %b want 0", kLast); else passes++;
      end
      if (i == 79) begin
        checks++; if (kWord !== 64'h6c44198c4a475817) $display("[TB] FAIL m1_word79: got %h want 6c44198c4a475817", kWord); else passes++;
        checks++; if (kLast !== 1'b1) $display("[TB] FAIL m1_last79: got %b want 1", kLast); else passes++;
      end
      hs++;
      step();
    end
    checks++; if (hs != 80) $display("[TB] FAIL m1_count: got %0d want 80", hs); else passes++;
    checks++; if (seqErr != 0) $display("[TB] FAIL m1_order: got %0d bad rounds want 0", seqErr); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL m1_end_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_backpressure();
    bit reached; int holdErr = 0;
    kReady = 1'b1;
    startSeq(1'b0);
    advanceTo(10, reached);
    checks++; if (!reached) $display("[TB] FAIL bp_reach10: got round %0d want 10", kRound); else passes++;
    kReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (kRound !== 7'd10 || kWord !== 64'h00000000243185be || kValid !== 1'b1 || kLast !== 1'b0) holdErr++;
    end
    checks++; if (holdErr != 0) $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", holdErr); else passes++;
    kReady = 1'b1;
    step();
    checks++; if (kRound !== 7'd11) $display("[TB] FAIL bp_resume_round: got %0d want 11", kRound); else passes++;
    checks++; if (kWord !== 64'h00000000550c7dc3) $display("[TB] FAIL bp_resume_word: got %h want 00000000550c7dc3", kWord); else passes++;
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_abort();
    bit reached;
    kReady = 1'b1;
    startSeq(1'b0);
    advanceTo(20, reached);
    checks++; if (!reached) $display("[TB] FAIL ab_reach20: got round %0d want 20", kRound); else passes++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (kValid !== 1'b0) $display("[TB] FAIL ab_valid: got %b want 0", kValid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL ab_busy: got %b want 0", busy); else passes++;
    startSeq(1'b0);
    checks++; if (kRound !== 7'd0 || kValid !== 1'b1) $display("[TB] FAIL ab_restart: got round %0d valid %b want 0/1", kRound, kValid); else passes++;
    checks++; if (kWord !== 64'h00000000428a2f98) $display("[TB] FAIL ab_restart_word: got %h want 00000000428a2f98", kWord); else passes++;
    abort = 1'b1; step();
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || kValid !== 1'b0) $display("[TB] FAIL ab_idle_start: got busy %b valid %b want 0/0", busy, kValid); else passes++;
  endtask

  task automatic test_reset_mid();
    bit reached; int activity = 0;
    kReady = 1'b1;
    startSeq(1'b1);
    advanceTo(40, reached);
    checks++; if (!reached) $display("[TB] FAIL mr_reach40: got round %0d want 40", kRound); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (kValid !== 1'b0 || busy !== 1'b0 || kLast !== 1'b0) $display("[TB] FAIL mr_flags: got valid %b busy %b last %b want 0", kValid, busy, kLast); else passes++;
    checks++; if (kWord !== 64'h0 || kRound !== 7'd0) $display("[TB] FAIL mr_data: got word %h round %0d want 0", kWord, kRound); else passes++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (kValid !== 1'b0 || busy !== 1'b0) activity++;
    end
    checks++; if (activity != 0) $display("[TB] FAIL mr_quiet: got %0d active cycles want 0", activity); else passes++;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    kReady = 1'b1;
    startSeq(1'b0);
    for (int i = 0; i < 100 && kValid; i++) begin
      cyc++;
      step();
    end
    checks++; if (cyc != 64 || kValid !== 1'b0) $display("[TB] FAIL b2b_first: got %0d cycles valid %b want 64/0", cyc, kValid); else passes++;
    startSeq(1'b1);
    checks++; if (kValid !== 1'b1 || kRound !== 7'd0) $display("[TB] FAIL b2b_second: got valid %b round %0d want 1/0", kValid, kRound); else passes++;
    checks++; if (kWord !== 64'h428a2f98d728ae22) $display("[TB] FAIL b2b_word: got %h want 428a2f98d728ae22", kWord); else passes++;
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_support256();
    int hs = 0; bit saw63 = 0;
    kReady2 = 1'b1;
    mode2   = 1'b1;
    start2  = 1'b1;
    step();
    start2  = 1'b0;
    checks++; if (kWord2 !== 64'h00000000428a2f98) $display("[TB] FAIL s256_word0: got %h want 00000000428a2f98", kWord2); else passes++;
    for (int i = 0; i < 120 && kValid2; i++) begin
      if (kRound2 == 7'd63 && kLast2 === 1'b1 && kWord2 === 64'h00000000c67178f2) saw63 = 1;
      hs++;
      step();
    end
    checks++; if (hs != 64) $display("[TB] FAIL s256_count: got %0d want 64", hs); else passes++;
    checks++; if (!saw63) $display("[TB] FAIL s256_last: got no final round 63 want one"); else passes++;
    checks++; if (busy2 !== 1'b0) $display("[TB] FAIL s256_end_busy: got %b want 0", busy2); else passes++;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_support256();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sha2_k_sequencer.md
SHA2_K_SEQUENCER -- requirements
Module: sha2_k_sequencer

Interface
REQ-001 SHALL have parameter SUPPORT_512, default 1, meaning 1 = SHA-512 mode available, 0 = SHA-256 only (mode input ignored, 64-bit table not synthesised).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a new K sequence; sampled only in IDLE.
REQ-005 SHALL have port mode, input, 1, 0 = SHA-224/256 (64 rounds, 32-bit K), 1 = SHA-384/512 (80 rounds, 64-bit K); sampled with start.
REQ-006 SHALL have port abort, input, 1, cancel the sequence in progress.
REQ-007 SHALL have port k_ready, input, 1, consumer accepts the current K word.
REQ-008 SHALL have port k_valid, output, 1, k_word/k_round/k_last are valid.
REQ-009 SHALL have port k_word, output, 64, round constant; SHA-256 mode places K in [31:0] with [63:32] = 0.
REQ-010 SHALL have port k_round, output, 7, index t of the presented constant.
REQ-011 SHALL have port k_last, output, 1, presented constant is the final round (63 or 79).
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE and RUN.
- IDLE: start=1 -> RUN; latch mode (forced to 0 when SUPPORT_512=0); load round 0.
- RUN: k_valid=1; on handshake (k_valid & k_ready) with k_last=0, advance to t+1 on the next cycle.
- RUN: a handshake with k_last=1 returns to IDLE.
REQ-014 SHALL present round 0 exactly one cycle after start is sampled; after that, one constant per cycle while k_ready stays high.
REQ-015 SHALL hold k_word, k_round and k_last stable while k_valid=1 and k_ready=0.
REQ-016 SHALL register all outputs; no combinational path from any input to any output.
REQ-017 SHALL derive K256[t] as bits [63:32] of K512[t] for t = 0..63, using a single 80-entry table.
REQ-018 SHALL set k_last=1 iff k_round equals 63 in mode 0 or 79 in mode 1.
REQ-019 SHALL ignore start while in RUN; the latched mode stays unchanged until the sequence ends.
REQ-020 SHALL, on abort=1 in RUN, enter IDLE on the next cycle with k_valid=0.
- abort has priority over a simultaneous handshake.
- abort in IDLE has no effect; abort and start together in IDLE leave the block in IDLE.
REQ-021 SHALL allow start in the cycle after the last handshake (IDLE), giving back-to-back sequences with one idle cycle between them.
REQ-022 SHALL never let the round counter wrap; there is no state beyond the last round.

Reset
REQ-023 SHALL, on rst=1, asynchronously force state IDLE and clear all outputs and registers to 0: k_valid=0, k_word=0, k_round=0, k_last=0, busy=0, latched mode=0.
REQ-024 SHALL abandon any sequence in progress when rst is asserted mid-sequence; after release, the block waits for a fresh start.

Structure
REQ-025 SHALL place in shared package sha2_pkg:
- FSM state enum;
- round-count constants ROUNDS_256=64 and ROUNDS_512=80;
- mode encodings.
REQ-026 SHALL isolate the 80x64 constant table in sub-module sha2_k_rom (combinational; input 7-bit index; output 64-bit K512). The sequencer registers the ROM output.

Verification
REQ-027 SHALL cover mode 0 with k_ready held at 1: start -> round 0 one cycle later, k_word=0x00000000428a2f98; 64 consecutive valid cycles; round 63 gives k_word=0x00000000c67178f2 with k_last=1; k_valid=0 and busy=0 the next cycle.
REQ-028 SHALL cover mode 1 with k_ready held at 1: start -> round 0 k_word=0x428a2f98d728ae22; round 63 = 0xc67178f2e372532b; round 79 = 0x6c44198c4a475817 with k_last=1; exactly 80 handshakes.
REQ-029 SHALL cover backpressure: in mode 0, k_ready low for 5 cycles at round 10 -> k_word stays 0x00000000243185be and k_round stays 10; the sequence resumes at round 11 when k_ready rises.
REQ-030 SHALL cover abort priority: abort asserted at round 20 together with k_ready=1 -> next cycle k_valid=0 and busy=0; a new start then restarts at round 0.
REQ-031 SHALL cover mid-sequence reset: rst asserted asynchronously (between clock edges) at round 40 of mode 1 -> all outputs read 0 immediately; no output activity until the next start.
REQ-032 SHALL cover SUPPORT_512=0: start with mode=1 -> a 64-round SHA-256 sequence, with round 0 k_word=0x00000000428a2f98.
